// File: rtl/alarm_sequencer.sv
// Alarm sequencer: filters the raw alarm request with an arming delay, latches the
// siren until acknowledged, blinks an indicator, re-arms on a persistent cause and counts events.
module alarm_sequencer #(
  parameter int DELAY     = 3,
  parameter int BLINK     = 2,
  parameter int REARM     = 8,
  parameter int NBITS_CNT = 8
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  input  logic                 alarm_req,
  input  logic                 ack,
  output logic                 sirene,
  output logic                 blink,
  output logic                 arming,
  output logic [1:0]           state_o,
  output logic [NBITS_CNT-1:0] alarm_count
);

  localparam int CMAX = (DELAY > REARM) ? DELAY : REARM;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(BLINK + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    ALARM    = 2'd2,
    SILENCED = 2'd3
  } state_t;

  state_t               state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [BW-1:0]        bcnt_q, bcnt_n;
  logic                 blink_q, blink_n;
  logic [NBITS_CNT-1:0] count_q, count_n;
  logic                 enter_alarm;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bcnt_q  <= bcnt_n;
      blink_q <= blink_n;
      count_q <= count_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    bcnt_n      = bcnt_q;
    blink_n     = blink_q;
    count_n     = count_q;
    enter_alarm = 1'b0;

    case (state_q)
      IDLE: begin
        if (alarm_req) begin
          state_n = ARMING;
          cnt_n   = CW'(DELAY - 1);
        end
      end
      ARMING: begin
        if (ack || !alarm_req) state_n = IDLE;
        else if (cnt_q == '0)  enter_alarm = 1'b1;
        else                   cnt_n = cnt_q - CW'(1);
      end
      ALARM: begin
        if (ack) begin
          state_n = SILENCED;
          cnt_n   = CW'(REARM - 1);
          blink_n = 1'b0;
          bcnt_n  = '0;
        end else if (bcnt_q == '0) begin
          blink_n = ~blink_q;
          bcnt_n  = BW'(BLINK - 1);
        end else begin
          bcnt_n  = bcnt_q - BW'(1);
        end
      end
      SILENCED: begin
        if (!alarm_req)       state_n = IDLE;
        else if (ack)         cnt_n = CW'(REARM - 1);
        else if (cnt_q == '0) enter_alarm = 1'b1;
        else                  cnt_n = cnt_q - CW'(1);
      end
      default: state_n = IDLE;
    endcase

    // Both entry paths share one place for blink restart and the saturating event count.
    if (enter_alarm) begin
      state_n = ALARM;
      blink_n = 1'b1;
      bcnt_n  = BW'(BLINK - 1);
      if (count_q != '1) count_n = count_q + NBITS_CNT'(1);
    end
  end

  assign sirene      = (state_q == ALARM);
  assign arming      = (state_q == ARMING);
  assign state_o     = state_q;
  assign blink       = blink_q;
  assign alarm_count = count_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios plus random stimulus
// compared against an elapsed-time reference model.
module tb_alarm_sequencer;

  localparam int DELAY = 3;
  localparam int BLINK = 2;
  localparam int REARM = 8;
  localparam int NBITS = 8;
  localparam int CMAXV = (1 << NBITS) - 1;

  logic             clk_2 = 1'b0;
  logic             reset_n = 1'b0;
  logic             alarm_req = 1'b0;
  logic             ack = 1'b0;
  logic             sirene, blink, arming;
  logic [1:0]       state_o;
  logic [NBITS-1:0] alarm_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode 0..3 = idle/arming/alarm/silenced, k = edges spent in the
  // current wait window, t = edges since the alarm was entered.
  int m_mode = 0;
  int m_k    = 0;
  int m_t    = 0;
  int m_cnt  = 0;

  alarm_sequencer #(.DELAY(DELAY), .BLINK(BLINK), .REARM(REARM), .NBITS_CNT(NBITS)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .alarm_req(alarm_req), .ack(ack),
    .sirene(sirene), .blink(blink), .arming(arming), .state_o(state_o),
    .alarm_count(alarm_count)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("sirene", 32'(sirene), 32'(m_mode == 2));
    chk("arming", 32'(arming), 32'(m_mode == 1));
    chk("state_o", 32'(state_o), 32'(m_mode));
    chk("blink", 32'(blink), 32'(m_mode == 2 && ((m_t / BLINK) % 2 == 0)));
    chk("alarm_count", 32'(alarm_count), 32'(m_cnt));
  endtask

  task automatic mdl_reset();
    m_mode = 0; m_k = 0; m_t = 0; m_cnt = 0;
  endtask

  task automatic mdl_fire();
    m_mode = 2;
    m_t    = 0;
    if (m_cnt < CMAXV) m_cnt++;
  endtask

  task automatic mdl_edge(input logic r, input logic a);
    case (m_mode)
      0: if (r) begin m_mode = 1; m_k = 0; end
      1: begin
        if (a || !r)            m_mode = 0;
        else if (m_k == DELAY-1) mdl_fire();
        else                    m_k++;
      end
      2: begin
        if (a) begin m_mode = 3; m_k = 0; end
        else m_t++;
      end
      default: begin
        if (!r)                  m_mode = 0;
        else if (a)              m_k = 0;
        else if (m_k == REARM-1) mdl_fire();
        else                     m_k++;
      end
    endcase
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick(input logic r, input logic a);
    alarm_req = r;
    ack       = a;
    @(posedge clk_2);
    mdl_edge(r, a);
    #1;
    check_all();
  endtask

  initial begin
    // Reset state
    mdl_reset();
    #2;
    check_all();
    repeat (2) @(posedge clk_2);
    #1 reset_n = 1'b1;
    check_all();

    // Short glitch: two high cycles then low
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);

    // Held request: fires on 4th edge, blink pattern, latched after req drops
    repeat (4) tick(1, 0);
    repeat (5) tick(1, 0);
    repeat (3) tick(0, 0);

    // Ack with req held -> silenced, re-arm after 8 edges
    tick(1, 1);
    repeat (8) tick(1, 0);
    tick(1, 0);

    // Silenced: req drop beats ack
    tick(1, 1);
    tick(0, 1);
    tick(0, 0);

    // Arming: ack beats expiry
    repeat (3) tick(1, 0);
    tick(1, 1);
    tick(0, 0);

    // Async reset mid-alarm, applied and released between edges
    repeat (6) tick(1, 0);
    #2 reset_n = 1'b0;
    mdl_reset();
    #1;
    check_all();
    #1 reset_n = 1'b1;
    tick(0, 0);

    // Random stimulus, request biased high so all states are visited
    for (int i = 0; i < 400; i++)
      tick(logic'($urandom_range(0, 99) < 80), logic'($urandom_range(0, 99) < 12));

    // Saturation of the event counter
    #2 reset_n = 1'b0;
    mdl_reset();
    #1 reset_n = 1'b1;
    repeat (4) tick(1, 0);
    for (int i = 0; i < 260; i++) begin
      tick(1, 1);
      repeat (REARM) tick(1, 0);
    end
    chk("count_saturated", 32'(alarm_count), 32'(CMAXV));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Sequential back-end for the combinational alarm circuits (bank-vault `alarme`, factory `sirene`). It consumes a raw alarm request and turns it into a controlled siren output.
- It filters short glitches on the request with an arming delay. Once the alarm fires it latches until acknowledged, drives a blinking indicator, re-arms if the cause persists, and counts alarm events.
- It sits between the combinational alarm logic, driven by SWI, and the LED/SEG outputs in top.

Parameters:
- DELAY, 3: cycles alarm_req must stay high in ARMING before the alarm fires (≥1).
- BLINK, 2: half-period of the blink output, in cycles (≥1).
- REARM, 8: cycles alarm_req must stay high in SILENCED before returning to ALARM (≥1).
- NBITS_CNT, 8: width of the event counter.

Ports:
- clk_2, input, 1: system clock (divided clock from top).
- reset_n, input, 1: reset, asynchronous, active-low.
- alarm_req, input, 1: raw alarm request from the combinational logic; synchronous to clk_2.
- ack, input, 1: manager acknowledge/silence, level-sampled each edge.
- sirene, output, 1: siren drive; 1 only in ALARM.
- blink, output, 1: blinking indicator; toggles in ALARM, 0 otherwise.
- arming, output, 1: 1 in ARMING (pre-alarm LED).
- state_o, output, 2: encoded state for the LCD display.
- alarm_count, output, NBITS_CNT: number of ALARM entries, saturating.

Behaviour:
- One clock; reset is asynchronous and active-low. All state and outputs are registered; there is no combinational path from input to output.
- Reset (reset_n=0, any time, including mid-ALARM):
  - state=IDLE, cnt=0, blink_cnt=0.
  - sirene=0, blink=0, arming=0, state_o=0, alarm_count=0.
- State encoding: IDLE=0, ARMING=1, ALARM=2, SILENCED=3. All outputs are Moore outputs of the registered state.
- IDLE:
  - alarm_req=1 → ARMING, cnt←DELAY-1.
  - ack is ignored.
- ARMING, priority ack > !req > expiry:
  - ack=1 → IDLE.
  - alarm_req=0 → IDLE (glitch rejected).
  - cnt==0 → ALARM.
  - Otherwise cnt←cnt-1.
  - Net effect: with req held, ALARM is entered on the (DELAY+1)th edge after req is first sampled.
- ALARM:
  - Latched; alarm_req is ignored.
  - ack=1 → SILENCED, cnt←REARM-1.
  - blink: set to 1 on entry with blink_cnt←BLINK-1. Each edge, if blink_cnt==0 then blink toggles and blink_cnt←BLINK-1, else blink_cnt decrements.
- SILENCED, priority !req > ack > expiry:
  - alarm_req=0 → IDLE.
  - ack=1 → cnt←REARM-1 (restart the re-arm window).
  - cnt==0 → ALARM.
  - Otherwise cnt←cnt-1.
- alarm_count: increments by 1 on every transition into ALARM (from ARMING or SILENCED). It saturates at 2^NBITS_CNT-1 and never wraps.
- Leaving ALARM: blink←0 and blink_cnt←0 on the same edge.
- Counter widths:
  - cnt width is clog2(max(DELAY,REARM)+1).
  - blink_cnt width is clog2(BLINK+1).
- DELAY=1: ALARM is entered on the 2nd edge with req high.
- BLINK=1: blink toggles every cycle.

Test Plan:
- Async reset mid-ALARM, with reset_n pulsed between edges → all outputs 0 immediately, before the next clk_2 edge; state_o=0.
- alarm_req high for 2 cycles then low (DELAY=3) → arming=1 for 2 cycles, returns to IDLE, sirene never 1, alarm_count=0.
- alarm_req held high → arming=1 for 3 cycles, sirene=1 on the 4th edge, alarm_count=1. blink sequence is 1,1,0,0,1,1 (BLINK=2). Dropping req keeps sirene=1.
- In ALARM, ack=1 for one cycle with req held high → SILENCED (state_o=3, sirene=0). After 8 more edges → ALARM, alarm_count=2.
- In SILENCED, drop req on the same edge that ack is asserted → IDLE (req priority). Separately, assert ack and expiry together in ARMING → IDLE.
- Force 256 ALARM entries with NBITS_CNT=8 → alarm_count stays at 255 and does not wrap to 0.
